// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the memory port arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {GNT_IF, GNT_LS} grant_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rw;
  } mem_req_t;
endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: round-robin choice between IF and LS, tie goes to whoever lost last
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
  input  grant_t last_grant,
  output logic   valid,
  output grant_t grant
);
  always_comb begin
    valid = if_req | ls_req;
    grant = (if_req & ls_req) ? ((last_grant == GNT_IF) ? GNT_LS : GNT_IF) : (ls_req ? GNT_LS : GNT_IF);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and LS with round-robin and a watchdog
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              cpu_clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  output logic              mem_sig,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_finish,
  output logic              busy,
  output logic              timeout_err
);
  arb_state_t        state, next;
  grant_t            gnt, last_grant, pick;
  logic              pick_valid, expire, go_resp;
  logic [31:0]       cnt;
  logic [DATA_W-1:0] rd;
  mem_req_t          req;

  mem_arb_rr_pick u_pick (
    .if_req    (if_req),
    .ls_req    (ls_req),
    .last_grant(last_grant),
    .valid     (pick_valid),
    .grant     (pick)
  );

  // the latch register is the memory-side bus, so it stays stable for the whole transaction
  assign mem_addr  = req.addr;
  assign mem_wdata = req.wdata;
  assign mem_rw    = req.rw;
  assign expire    = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign go_resp   = (state == WAIT) && (mem_finish || expire);
  assign rd        = mem_finish ? mem_rdata : '0;

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = pick_valid ? ISSUE : IDLE;
      ISSUE:   next = WAIT;
      WAIT:    next = go_resp ? RESP : WAIT;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= next;

  always_ff @(posedge cpu_clk or negedge rstn) begin
    if (!rstn) begin
      gnt         <= GNT_IF;
      last_grant  <= GNT_IF;
      req         <= '0;
      cnt         <= '0;
      mem_sig     <= 1'b0;
      busy        <= 1'b0;
      if_done     <= 1'b0;
      ls_done     <= 1'b0;
      if_rdata    <= '0;
      ls_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      mem_sig  <= next == ISSUE;
      busy     <= next != IDLE;
      if_done  <= go_resp && gnt == GNT_IF;
      ls_done  <= go_resp && gnt == GNT_LS;
      if_rdata <= (go_resp && gnt == GNT_IF) ? rd : '0;
      ls_rdata <= (go_resp && gnt == GNT_LS && req.rw) ? rd : '0;
      cnt      <= (state == WAIT) ? cnt + 32'd1 : '0;
      if (go_resp && !mem_finish) timeout_err <= 1'b1;
      if (state == IDLE && pick_valid) begin
        gnt        <= pick;
        last_grant <= pick;
        req        <= (pick == GNT_LS) ? mem_req_t'{ls_addr, ls_wdata, !ls_we} : mem_req_t'{if_addr, '0, 1'b1};
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests of grant order, data return, watchdog and reset abort
module tb_mem_port_arbiter;
  logic        cpu_clk = 0, rstn = 0;
  logic        if_req = 0, ls_req = 0, ls_we = 0, mem_finish = 0;
  logic [26:0] if_addr = 0, ls_addr = 0;
  logic [31:0] ls_wdata = 0, mem_rdata = 0;
  logic        if_done, ls_done, mem_rw, mem_sig, busy, timeout_err;
  logic [31:0] if_rdata, ls_rdata, mem_wdata;
  logic [26:0] mem_addr;
  int checks = 0, passed = 0;

  always #5 cpu_clk = ~cpu_clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .cpu_clk(cpu_clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_sig(mem_sig),
    .mem_rdata(mem_rdata), .mem_finish(mem_finish), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic do_reset();
    @(negedge cpu_clk);
    rstn = 0;
    repeat (2) @(negedge cpu_clk);
    rstn = 1;
  endtask

  // memory model: waits for mem_sig, pulses finish dly cycles later (if fin), returns when a done is seen
  task automatic serve(input int dly, input logic [31:0] data, input bit fin, input bit hold,
                       output int sigs, output int when, output logic got_if, output logic got_ls,
                       output logic [31:0] ifr, output logic [31:0] lsr,
                       output logic [26:0] a_s, output logic [31:0] w_s, output logic rw_s);
    int n = 0;
    sigs = 0; when = -1; got_if = 0; got_ls = 0; ifr = 0; lsr = 0; a_s = 0; w_s = 0; rw_s = 0;
    do begin @(negedge cpu_clk); n++; end while (!mem_sig && n < 20);
    if (!mem_sig) return;
    sigs = 1; a_s = mem_addr; w_s = mem_wdata; rw_s = mem_rw;
    for (int i = 1; i <= 40; i++) begin
      @(negedge cpu_clk);
      mem_finish = 0;
      if (mem_sig) sigs++;
      if (if_done || ls_done) begin
        when = i; got_if = if_done; got_ls = ls_done; ifr = if_rdata; lsr = ls_rdata;
        if (!hold) begin
          if (if_done) if_req = 0;
          if (ls_done) ls_req = 0;
        end
        return;
      end
      if (fin && i == dly) begin mem_finish = 1; mem_rdata = data; end
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    @(negedge cpu_clk);
    checks++; if ({busy, mem_sig, if_done, ls_done, timeout_err, mem_rw} !== 6'b0) $display("FAIL reset_outputs got %b want 000000", {busy, mem_sig, if_done, ls_done, timeout_err, mem_rw}); else passed++;
    checks++; if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== '0) $display("FAIL reset_buses got nonzero want 0"); else passed++;
    rstn = 1;
  endtask

  task automatic test_if_read();
    int s, w; logic gi, gl, rw; logic [31:0] ir, lr, wd; logic [26:0] a;
    @(negedge cpu_clk);
    if_addr = 27'h0000100; if_req = 1;
    serve(5, 32'h12345678, 1, 0, s, w, gi, gl, ir, lr, a, wd, rw);
    checks++; if (s !== 1) $display("FAIL if_sig_count got %0d want 1", s); else passed++;
    checks++; if (rw !== 1'b1 || a !== 27'h0000100) $display("FAIL if_issue got rw=%b addr=%h want rw=1 addr=0000100", rw, a); else passed++;
    checks++; if (gi !== 1'b1 || gl !== 1'b0) $display("FAIL if_done got if=%b ls=%b want if=1 ls=0", gi, gl); else passed++;
    checks++; if (ir !== 32'h12345678) $display("FAIL if_rdata got %h want 12345678", ir); else passed++;
    checks++; if (w !== 6) $display("FAIL if_latency got %0d want 6", w); else passed++;
    @(negedge cpu_clk);
    checks++; if (busy !== 1'b0 || if_done !== 1'b0) $display("FAIL if_after got busy=%b done=%b want 0 0", busy, if_done); else passed++;
  endtask

  task automatic test_ls_write();
    int s, w; logic gi, gl, rw; logic [31:0] ir, lr, wd; logic [26:0] a;
    @(negedge cpu_clk);
    ls_addr = 27'h7FFFFFF; ls_wdata = 32'hCAFEBABE; ls_we = 1; ls_req = 1;
    serve(3, 32'hDEADBEEF, 1, 0, s, w, gi, gl, ir, lr, a, wd, rw);
    checks++; if (rw !== 1'b0 || wd !== 32'hCAFEBABE || a !== 27'h7FFFFFF) $display("FAIL ls_issue got rw=%b wdata=%h addr=%h want 0 cafebabe 7ffffff", rw, wd, a); else passed++;
    checks++; if (gl !== 1'b1 || gi !== 1'b0) $display("FAIL ls_done got if=%b ls=%b want if=0 ls=1", gi, gl); else passed++;
    checks++; if (lr !== 32'h0) $display("FAIL ls_wr_rdata got %h want 0", lr); else passed++;
    checks++; if (w !== 4) $display("FAIL ls_latency got %0d want 4", w); else passed++;
    ls_we = 0;
  endtask

  task automatic test_round_robin();
    int s, w; logic gi, gl, rw; logic [31:0] ir, lr, wd; logic [26:0] a;
    int nif = 0, nls = 0;
    logic [3:0] exp_ls = 4'b0101;
    rstn = 0;
    if_addr = 27'h11; ls_addr = 27'h22; ls_we = 0; if_req = 1; ls_req = 1;
    repeat (2) @(negedge cpu_clk);
    rstn = 1;
    for (int k = 0; k < 4; k++) begin
      serve(2, 32'h100 + k, 1, 1, s, w, gi, gl, ir, lr, a, wd, rw);
      nif += int'(gi); nls += int'(gl);
      checks++; if (gl !== exp_ls[k] || gi !== !exp_ls[k] || a !== (exp_ls[k] ? 27'h22 : 27'h11)) $display("FAIL rr_grant_%0d got if=%b ls=%b addr=%h want ls=%b", k, gi, gl, a, exp_ls[k]); else passed++;
      checks++; if ((exp_ls[k] ? lr : ir) !== 32'h100 + k) $display("FAIL rr_data_%0d got if=%h ls=%h want %h", k, ir, lr, 32'h100 + k); else passed++;
    end
    if_req = 0; ls_req = 0;
    checks++; if (nif !== 2 || nls !== 2) $display("FAIL rr_counts got if=%0d ls=%0d want 2 2", nif, nls); else passed++;
  endtask

  task automatic test_timeout();
    int s, w; logic gi, gl, rw; logic [31:0] ir, lr, wd; logic [26:0] a;
    do_reset();
    checks++; if (timeout_err !== 1'b0) $display("FAIL to_pre got %b want 0", timeout_err); else passed++;
    if_addr = 27'h33; if_req = 1;
    serve(0, 32'hFFFFFFFF, 0, 0, s, w, gi, gl, ir, lr, a, wd, rw);
    checks++; if (gi !== 1'b1 || w !== 17 || ir !== 32'h0) $display("FAIL to_done got done=%b at=%0d rdata=%h want 1 17 0", gi, w, ir); else passed++;
    checks++; if (timeout_err !== 1'b1) $display("FAIL to_flag got %b want 1", timeout_err); else passed++;
    ls_addr = 27'h44; ls_we = 0; ls_req = 1;
    serve(2, 32'hA5A5A5A5, 1, 0, s, w, gi, gl, ir, lr, a, wd, rw);
    checks++; if (gl !== 1'b1 || lr !== 32'hA5A5A5A5) $display("FAIL to_good got done=%b rdata=%h want 1 a5a5a5a5", gl, lr); else passed++;
    checks++; if (timeout_err !== 1'b1) $display("FAIL to_sticky got %b want 1", timeout_err); else passed++;
    @(negedge cpu_clk); rstn = 0; #1;
    checks++; if (timeout_err !== 1'b0) $display("FAIL to_clear got %b want 0", timeout_err); else passed++;
    @(negedge cpu_clk); rstn = 1;
  endtask

  task automatic test_reset_mid();
    int n = 0; logic seen = 0;
    @(negedge cpu_clk);
    ls_addr = 27'h55; ls_we = 0; ls_req = 1;
    do begin @(negedge cpu_clk); n++; end while (!mem_sig && n < 20);
    checks++; if (mem_sig !== 1'b1) $display("FAIL rm_issue got mem_sig=%b want 1", mem_sig); else passed++;
    repeat (2) @(negedge cpu_clk);
    rstn = 0; ls_req = 0; #1;
    checks++; if (busy !== 1'b0 || mem_sig !== 1'b0 || ls_done !== 1'b0) $display("FAIL rm_abort got busy=%b sig=%b done=%b want 0 0 0", busy, mem_sig, ls_done); else passed++;
    @(negedge cpu_clk); rstn = 1;
    @(negedge cpu_clk); mem_finish = 1; mem_rdata = 32'h77777777;
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clk); mem_finish = 0;
      if (if_done || ls_done || busy || mem_sig) seen = 1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL rm_stray got activity=%b want 0", seen); else passed++;
  endtask

  task automatic test_finish_on_expiry();
    int s, w; logic gi, gl, rw; logic [31:0] ir, lr, wd; logic [26:0] a;
    do_reset();
    if_addr = 27'h66; if_req = 1;
    serve(16, 32'h0BADF00D, 1, 0, s, w, gi, gl, ir, lr, a, wd, rw);
    checks++; if (gi !== 1'b1 || w !== 17 || ir !== 32'h0BADF00D) $display("FAIL fe_done got done=%b at=%0d rdata=%h want 1 17 0badf00d", gi, w, ir); else passed++;
    checks++; if (timeout_err !== 1'b0) $display("FAIL fe_flag got %b want 0", timeout_err); else passed++;
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_ls_write();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_finish_on_expiry();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
